// File: rtl/line_buffer_sched_if.sv
// Video-in / line-buffer-control bundle for line_buffer_sched.
// master: video source and buffer user; slave: the scheduler.
interface line_buffer_sched_if #(
  parameter int ADDR_W = 10
);
  logic              i_vsync;
  logic              i_hsync;
  logic              i_pixel_stb;
  logic              o_wr_en;
  logic [1:0]        o_wr_sel;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [1:0]        o_rd_top;
  logic [1:0]        o_rd_mid;
  logic              o_window_valid;
  logic              o_frame_done;
  logic [ADDR_W-1:0] o_line_count;
  logic              o_overflow;

  modport master (
    output i_vsync, i_hsync, i_pixel_stb,
    input  o_wr_en, o_wr_sel, o_wr_addr,
    input  o_rd_top, o_rd_mid, o_window_valid,
    input  o_frame_done, o_line_count, o_overflow
  );

  modport slave (
    input  i_vsync, i_hsync, i_pixel_stb,
    output o_wr_en, o_wr_sel, o_wr_addr,
    output o_rd_top, o_rd_mid, o_window_valid,
    output o_frame_done, o_line_count, o_overflow
  );
endinterface

// File: rtl/line_buffer_sched.sv
// 3-line buffer write/read scheduler for a 3x3 window filter.
// Ports: i_clk, i_reset_n (async low), i_enable, bus (slave modport).
module line_buffer_sched #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int ADDR_W     = 10
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_enable,
  line_buffer_sched_if.slave  bus
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] WMAX = CW'(IMG_WIDTH);
  localparam logic [ADDR_W-1:0] HMAX = ADDR_W'(IMG_HEIGHT);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_FILL, S_ACT
  } state_t;

  state_t r_state, w_nstate;

  logic              r_vs_d, r_hs_d;
  logic [CW-1:0]     r_col;
  logic [ADDR_W-1:0] r_cnt;
  logic [1:0]        r_wr_sel;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_wr_en, r_win, r_done;
  logic              r_ovf, r_eol;

  logic              w_vs_rise, w_vs_fall, w_hs_fall;
  logic              w_run, w_act, w_hit;
  logic              w_accept, w_ovf, w_eol, w_done;
  logic [ADDR_W-1:0] w_cnt_nx;
  logic [1:0]        w_sel_nx;
  logic [1:0]        w_rd_top, w_rd_mid;

  assign w_vs_rise = bus.i_vsync & ~r_vs_d;
  assign w_vs_fall = r_vs_d & ~bus.i_vsync;
  assign w_hs_fall = r_hs_d & ~bus.i_hsync;
  assign w_cnt_nx  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_sel_nx  = (r_wr_sel == 2'd2) ? 2'd0 : r_wr_sel + 2'd1;

  // The hsync falling-edge cycle still qualifies a strobe, so the
  // last pixel of a line may coincide with the edge.
  assign w_hit    = w_run & ~w_vs_rise & bus.i_pixel_stb
                  & (bus.i_hsync | r_hs_d);
  assign w_accept = w_hit & (r_col < WMAX);
  assign w_ovf    = w_hit & ~(r_col < WMAX);
  assign w_eol    = w_run & ~w_vs_rise & w_hs_fall
                  & ((r_col != '0) | w_accept);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    if (!i_enable) begin
      w_nstate = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: w_nstate = S_WAIT;
        S_WAIT: if (w_vs_fall) w_nstate = S_FILL;
        S_FILL, S_ACT: begin
          if (w_vs_rise)
            w_nstate = S_WAIT;
          else if (r_eol && w_cnt_nx == HMAX)
            w_nstate = S_WAIT;
          else if (r_eol && r_state == S_FILL
                   && w_cnt_nx >= ADDR_W'(2))
            w_nstate = S_ACT;
        end
      endcase
    end
  end

  always_comb begin
    w_run    = i_enable
             & ((r_state == S_FILL) | (r_state == S_ACT));
    w_act    = i_enable & (r_state == S_ACT);
    w_done   = w_run & ~w_vs_rise & r_eol
             & (w_cnt_nx == HMAX);
    w_rd_top = (r_wr_sel == 2'd2) ? 2'd0 : r_wr_sel + 2'd1;
    w_rd_mid = (r_wr_sel == 2'd0) ? 2'd2 : r_wr_sel - 2'd1;
  end

  // Rotation and count update lag the line end by one cycle so a
  // pixel accepted on the edge cycle is shown against the old wr_sel.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_vs_d    <= 1'b0;
      r_hs_d    <= 1'b0;
      r_col     <= '0;
      r_cnt     <= '0;
      r_wr_sel  <= 2'd0;
      r_wr_addr <= '0;
      r_wr_en   <= 1'b0;
      r_win     <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_eol     <= 1'b0;
    end else begin
      r_vs_d  <= bus.i_vsync;
      r_hs_d  <= bus.i_hsync;
      r_wr_en <= w_accept;
      r_win   <= w_accept & w_act & (r_col >= CW'(2));
      r_done  <= w_done;
      if (w_accept) r_wr_addr <= r_col[ADDR_W-1:0];
      if (r_state == S_IDLE) begin
        r_col     <= '0;
        r_cnt     <= '0;
        r_wr_sel  <= 2'd0;
        r_wr_addr <= '0;
        r_ovf     <= 1'b0;
        r_eol     <= 1'b0;
      end else if (r_state == S_WAIT) begin
        r_eol <= 1'b0;
        if (w_vs_fall) begin
          r_col    <= '0;
          r_cnt    <= '0;
          r_wr_sel <= 2'd0;
        end
      end else if (w_vs_rise) begin
        r_col    <= '0;
        r_cnt    <= '0;
        r_wr_sel <= 2'd0;
        r_eol    <= 1'b0;
      end else begin
        r_eol <= w_eol;
        if (w_ovf) r_ovf <= 1'b1;
        if (w_eol)
          r_col <= '0;
        else if (w_accept)
          r_col <= r_col + CW'(1);
        if (r_eol && w_run) begin
          r_cnt    <= w_cnt_nx;
          r_wr_sel <= w_sel_nx;
        end
      end
    end
  end

  assign bus.o_wr_en        = r_wr_en;
  assign bus.o_wr_sel       = r_wr_sel;
  assign bus.o_wr_addr      = r_wr_addr;
  assign bus.o_rd_top       = w_rd_top;
  assign bus.o_rd_mid       = w_rd_mid;
  assign bus.o_window_valid = r_win;
  assign bus.o_frame_done   = r_done;
  assign bus.o_line_count   = r_cnt;
  assign bus.o_overflow     = r_ovf;

endmodule

// File: tb/tb_line_buffer_sched.sv
// Directed bench for line_buffer_sched (8x4 image).
// Drives via the interface, checks inline per scenario task.
module tb_line_buffer_sched;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  line_buffer_sched_if #(.ADDR_W(AW)) bus ();

  line_buffer_sched #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_enable(en), .bus(bus)
  );

  int n_wr = 0;
  int n_win = 0;
  int n_done = 0;
  int n_win_bad = 0;
  logic [AW-1:0] a_log[$];
  logic [1:0]    s_log[$];

  always @(negedge clk) begin
    if (bus.o_wr_en) begin
      n_wr++;
      a_log.push_back(bus.o_wr_addr);
      s_log.push_back(bus.o_wr_sel);
      if (bus.o_window_valid) n_win++;
    end else if (bus.o_window_valid) begin
      n_win_bad++;
    end
    if (bus.o_frame_done) n_done++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    bus.i_vsync = 1'b1;
    tick();
    bus.i_vsync = 1'b0;
    tick();
  endtask

  task automatic line(input int n, input bit fall_stb);
    bus.i_hsync = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.i_pixel_stb = 1'b1;
      tick();
    end
    bus.i_hsync = 1'b0;
    bus.i_pixel_stb = fall_stb;
    tick();
    bus.i_pixel_stb = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    checks++;
    if (bus.o_wr_en !== 1'b0 || bus.o_window_valid !== 1'b0
        || bus.o_frame_done !== 1'b0 || bus.o_overflow !== 1'b0) begin
      errs++;
      $display("FAIL reset_flags: en=%b win=%b done=%b ovf=%b want 0",
               bus.o_wr_en, bus.o_window_valid,
               bus.o_frame_done, bus.o_overflow);
    end
    checks++;
    if (bus.o_wr_sel !== 2'd0 || bus.o_rd_top !== 2'd1
        || bus.o_rd_mid !== 2'd2) begin
      errs++;
      $display("FAIL reset_sel: sel=%0d top=%0d mid=%0d want 0/1/2",
               bus.o_wr_sel, bus.o_rd_top, bus.o_rd_mid);
    end
    checks++;
    if (bus.o_wr_addr !== '0 || bus.o_line_count !== '0) begin
      errs++;
      $display("FAIL reset_cnt: addr=%0d cnt=%0d want 0/0",
               bus.o_wr_addr, bus.o_line_count);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_frame();
    int w0, v0, d0, v1;
    logic [1:0] exp_sel[4];
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd0};
    en = 1'b1;
    tick();
    vs_pulse();
    w0 = n_wr; d0 = n_done;
    for (int l = 0; l < 4; l++) begin
      checks++;
      if (bus.o_wr_sel !== exp_sel[l]
          || bus.o_rd_top !== (exp_sel[l] + 2'd1) % 3
          || bus.o_rd_mid !== (exp_sel[l] + 2'd2) % 3) begin
        errs++;
        $display("FAIL frame_sel l%0d: sel=%0d top=%0d mid=%0d want sel %0d",
                 l, bus.o_wr_sel, bus.o_rd_top, bus.o_rd_mid, exp_sel[l]);
      end
      v0 = n_win;
      line(8, 1'b0);
      v1 = (l >= 2) ? 6 : 0;
      checks++;
      if (n_win - v0 !== v1) begin
        errs++;
        $display("FAIL frame_win l%0d: got %0d want %0d",
                 l, n_win - v0, v1);
      end
    end
    checks++;
    if (n_wr - w0 !== 32) begin
      errs++;
      $display("FAIL frame_writes: got %0d want 32", n_wr - w0);
    end
    checks++;
    if (n_done - d0 !== 1) begin
      errs++;
      $display("FAIL frame_done: got %0d want 1", n_done - d0);
    end
    checks++;
    if (bus.o_line_count !== 4'd4) begin
      errs++;
      $display("FAIL frame_cnt: got %0d want 4", bus.o_line_count);
    end
    w0 = n_wr;
    line(8, 1'b0);
    checks++;
    if (n_wr - w0 !== 0) begin
      errs++;
      $display("FAIL frame_after: got %0d writes want 0", n_wr - w0);
    end
  endtask

  task automatic test_overflow();
    int w0, q0, bad;
    vs_pulse();
    w0 = n_wr; q0 = a_log.size();
    line(9, 1'b0);
    checks++;
    if (n_wr - w0 !== 8) begin
      errs++;
      $display("FAIL ovf_writes: got %0d want 8", n_wr - w0);
    end
    bad = 0;
    for (int i = 0; i < 8 && q0 + i < a_log.size(); i++)
      if (a_log[q0 + i] !== AW'(i)) bad++;
    checks++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL ovf_addr: got %0d bad addrs want 0", bad);
    end
    checks++;
    if (bus.o_overflow !== 1'b1) begin
      errs++;
      $display("FAIL ovf_set: got %b want 1", bus.o_overflow);
    end
    line(8, 1'b0);
    checks++;
    if (bus.o_overflow !== 1'b1) begin
      errs++;
      $display("FAIL ovf_sticky: got %b want 1", bus.o_overflow);
    end
  endtask

  task automatic test_enable_drop();
    int w0;
    bus.i_hsync = 1'b1;
    bus.i_pixel_stb = 1'b1;
    tick(); tick(); tick();
    en = 1'b0;
    tick();
    checks++;
    if (bus.o_wr_en !== 1'b0 || bus.o_window_valid !== 1'b0) begin
      errs++;
      $display("FAIL drop_wr: en=%b win=%b want 0/0",
               bus.o_wr_en, bus.o_window_valid);
    end
    tick();
    checks++;
    if (bus.o_overflow !== 1'b0 || bus.o_line_count !== '0
        || bus.o_wr_sel !== 2'd0) begin
      errs++;
      $display("FAIL drop_idle: ovf=%b cnt=%0d sel=%0d want 0/0/0",
               bus.o_overflow, bus.o_line_count, bus.o_wr_sel);
    end
    bus.i_hsync = 1'b0;
    bus.i_pixel_stb = 1'b0;
    tick();
    en = 1'b1;
    tick();
    w0 = n_wr;
    line(8, 1'b0);
    checks++;
    if (n_wr - w0 !== 0) begin
      errs++;
      $display("FAIL drop_novs: got %0d writes want 0", n_wr - w0);
    end
    vs_pulse();
    w0 = n_wr;
    line(8, 1'b0);
    checks++;
    if (n_wr - w0 !== 8) begin
      errs++;
      $display("FAIL drop_resume: got %0d writes want 8", n_wr - w0);
    end
  endtask

  task automatic test_abort();
    int d0, q0;
    vs_pulse();
    d0 = n_done;
    line(8, 1'b0);
    line(8, 1'b0);
    bus.i_vsync = 1'b1;
    tick();
    checks++;
    if (bus.o_line_count !== '0) begin
      errs++;
      $display("FAIL abort_cnt: got %0d want 0", bus.o_line_count);
    end
    tick();
    tick();
    checks++;
    if (n_done - d0 !== 0) begin
      errs++;
      $display("FAIL abort_done: got %0d want 0", n_done - d0);
    end
    bus.i_vsync = 1'b0;
    tick();
    q0 = s_log.size();
    line(8, 1'b0);
    checks++;
    if (s_log.size() <= q0 || s_log[q0] !== 2'd0) begin
      errs++;
      $display("FAIL abort_sel: got %0d writes / sel %0d want sel 0",
               s_log.size() - q0,
               (s_log.size() > q0) ? s_log[q0] : 2'd3);
    end
  endtask

  task automatic test_same_cycle();
    int w0, q0, bad;
    vs_pulse();
    w0 = n_wr; q0 = a_log.size();
    line(3, 1'b1);
    checks++;
    if (n_wr - w0 !== 4) begin
      errs++;
      $display("FAIL edge_writes: got %0d want 4", n_wr - w0);
    end
    bad = 0;
    for (int i = 0; i < 4 && q0 + i < a_log.size(); i++)
      if (a_log[q0 + i] !== AW'(i) || s_log[q0 + i] !== 2'd0) bad++;
    checks++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL edge_addr_sel: got %0d bad writes want 0", bad);
    end
    checks++;
    if (bus.o_wr_sel !== 2'd1 || bus.o_line_count !== 4'd1) begin
      errs++;
      $display("FAIL edge_rot: sel=%0d cnt=%0d want 1/1",
               bus.o_wr_sel, bus.o_line_count);
    end
  endtask

  task automatic test_async_reset();
    int w0;
    bus.i_hsync = 1'b1;
    bus.i_pixel_stb = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.o_wr_en !== 1'b1) begin
      errs++;
      $display("FAIL arst_pre: wr_en=%b want 1", bus.o_wr_en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_wr_en !== 1'b0 || bus.o_wr_sel !== 2'd0
        || bus.o_line_count !== '0 || bus.o_wr_addr !== '0) begin
      errs++;
      $display("FAIL arst_now: en=%b sel=%0d cnt=%0d addr=%0d want 0",
               bus.o_wr_en, bus.o_wr_sel,
               bus.o_line_count, bus.o_wr_addr);
    end
    checks++;
    if (bus.o_rd_top !== 2'd1 || bus.o_rd_mid !== 2'd2) begin
      errs++;
      $display("FAIL arst_rd: top=%0d mid=%0d want 1/2",
               bus.o_rd_top, bus.o_rd_mid);
    end
    #2;
    rst_n = 1'b1;
    bus.i_hsync = 1'b0;
    bus.i_pixel_stb = 1'b0;
    tick();
    tick();
    w0 = n_wr;
    line(8, 1'b0);
    checks++;
    if (n_wr - w0 !== 0) begin
      errs++;
      $display("FAIL arst_novs: got %0d writes want 0", n_wr - w0);
    end
    vs_pulse();
    w0 = n_wr;
    line(8, 1'b0);
    checks++;
    if (n_wr - w0 !== 8) begin
      errs++;
      $display("FAIL arst_resume: got %0d writes want 8", n_wr - w0);
    end
  endtask

  initial begin
    bus.i_vsync = 1'b0;
    bus.i_hsync = 1'b0;
    bus.i_pixel_stb = 1'b0;
    #3;
    test_reset();
    test_frame();
    test_overflow();
    test_enable_drop();
    test_abort();
    test_same_cycle();
    test_async_reset();
    checks++;
    if (n_win_bad !== 0) begin
      errs++;
      $display("FAIL win_without_wr: got %0d want 0", n_win_bad);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
